fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a requested number of words from a show-ahead FIFO
// into a 2-entry skid buffer and presents them on a valid/ready stream.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  fifo_rd_req,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  localparam int unsigned BUF_CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [BUF_CNT_W-1:0]  r_buf_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_load;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_xfer;

  // Pop only while reading with room in the buffer; no dependence on m_ready.
  assign w_push = (r_state == S_READ) && !fifo_rd_empty &&
                  (r_remaining != '0) && (r_buf_cnt < BUF_CNT_W'(2));
  assign w_xfer = m_valid && m_ready;

  assign fifo_rd_req = w_push;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign rd_count    = r_rd_count;
  assign m_valid     = (r_buf_cnt != '0);
  assign m_data      = r_buf0;

  // State and done-pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, done and load/flush decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            w_state_nxt = S_READ;
            w_load      = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
        end else if (w_push && (r_remaining == CNT_WIDTH'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
        end else if (w_xfer && (r_buf_cnt == BUF_CNT_W'(1))) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: words still to pop and words popped so far.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_remaining <= '0;
      r_rd_count  <= '0;
    end else if (w_load) begin
      r_remaining <= burst_len;
      r_rd_count  <= '0;
    end else begin
      if (w_push) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
        r_rd_count  <= r_rd_count + CNT_WIDTH'(1);
      end
      if (w_flush) begin
        r_remaining <= '0;
      end
    end
  end

  // Two-entry output buffer; entry 0 is always the oldest word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_cnt <= '0;
      r_buf0    <= '0;
      r_buf1    <= '0;
    end else if (w_flush) begin
      r_buf_cnt <= '0;
    end else begin
      case ({w_push, w_xfer})
        2'b10: begin
          if (r_buf_cnt == '0) begin
            r_buf0 <= fifo_q;
          end else begin
            r_buf1 <= fifo_q;
          end
          r_buf_cnt <= r_buf_cnt + BUF_CNT_W'(1);
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - BUF_CNT_W'(1);
        end
        2'b11: begin
          // Push needs a free slot and a transfer needs a word, so exactly one is held.
          r_buf0 <= fifo_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
